// File: rtl/alarm_clock.sv
// alarm_clock: 24-hour BCD real-time clock with one armable hh:mm alarm.
// Optional feature macro ALARM_TIMEOUT_EN: a ringing alarm auto-clears after 60 second ticks.
module alarm_clock #(
  parameter int unsigned TICKS_PER_SEC = 100
) (
  input  logic       rst_bar,
  input  logic       clk,
  input  logic [1:0] h1_in,
  input  logic [3:0] h0_in,
  input  logic [2:0] m1_in,
  input  logic [3:0] m0_in,
  input  logic       load_time,
  input  logic       load_alarm,
  input  logic       set_alarm,
  input  logic       stop_alarm,
  output logic       alarm,
  output logic [1:0] h1_out,
  output logic [3:0] h0_out,
  output logic [2:0] m1_out,
  output logic [3:0] m0_out,
  output logic [2:0] s1_out,
  output logic [3:0] s0_out
);

  localparam int unsigned CW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [CW-1:0] PRESC_MAX = CW'(TICKS_PER_SEC - 1);

  logic [CW-1:0] presc_q, presc_d;
  logic [1:0]    h1_q, h1_d;
  logic [3:0]    h0_q, h0_d;
  logic [2:0]    m1_q, m1_d;
  logic [3:0]    m0_q, m0_d;
  logic [2:0]    s1_q, s1_d;
  logic [3:0]    s0_q, s0_d;
  logic [1:0]    ah1_q, ah1_d;
  logic [3:0]    ah0_q, ah0_d;
  logic [2:0]    am1_q, am1_d;
  logic [3:0]    am0_q, am0_d;
  logic          alarm_q, alarm_d;

  logic in_valid_c;
  logic tick_c;
  logic match_c;
  logic timeout_c;

  // Digit inputs must form a legal 24-hour hh:mm
  assign in_valid_c = (h1_in <= 2'd2) && (h0_in <= 4'd9) &&
                      ((h1_in != 2'd2) || (h0_in <= 4'd3)) &&
                      (m1_in <= 3'd5) && (m0_in <= 4'd9);

  assign tick_c  = (presc_q == PRESC_MAX);
  assign match_c = set_alarm &&
                   ({h1_q, h0_q, m1_q, m0_q} == {ah1_q, ah0_q, am1_q, am0_q}) &&
                   (s1_q == 3'd0) && (s0_q == 4'd0);

`ifdef ALARM_TIMEOUT_EN
  logic [5:0] to_cnt_q, to_cnt_d;

  // Counts second ticks while ringing; restarts from zero whenever the alarm is idle
  assign timeout_c = alarm_q && tick_c && (to_cnt_q == 6'd59);
  assign to_cnt_d  = alarm_q ? (tick_c ? to_cnt_q + 6'd1 : to_cnt_q) : 6'd0;

  always_ff @(posedge clk or negedge rst_bar) begin
    if (!rst_bar) to_cnt_q <= 6'd0;
    else          to_cnt_q <= to_cnt_d;
  end
`else
  assign timeout_c = 1'b0;
`endif

  // Time next-state: a valid load wins over ticking and restarts the second
  always_comb begin
    presc_d = presc_q + 1'b1;
    h1_d    = h1_q;
    h0_d    = h0_q;
    m1_d    = m1_q;
    m0_d    = m0_q;
    s1_d    = s1_q;
    s0_d    = s0_q;
    if (load_time && in_valid_c) begin
      presc_d = '0;
      h1_d    = h1_in;
      h0_d    = h0_in;
      m1_d    = m1_in;
      m0_d    = m0_in;
      s1_d    = 3'd0;
      s0_d    = 4'd0;
    end else if (tick_c) begin
      presc_d = '0;
      if (s0_q != 4'd9) begin
        s0_d = s0_q + 4'd1;
      end else begin
        s0_d = 4'd0;
        if (s1_q != 3'd5) begin
          s1_d = s1_q + 3'd1;
        end else begin
          s1_d = 3'd0;
          if (m0_q != 4'd9) begin
            m0_d = m0_q + 4'd1;
          end else begin
            m0_d = 4'd0;
            if (m1_q != 3'd5) begin
              m1_d = m1_q + 3'd1;
            end else begin
              m1_d = 3'd0;
              if ((h1_q == 2'd2) && (h0_q == 4'd3)) begin
                h1_d = 2'd0;
                h0_d = 4'd0;
              end else if (h0_q == 4'd9) begin
                h1_d = h1_q + 2'd1;
                h0_d = 4'd0;
              end else begin
                h0_d = h0_q + 4'd1;
              end
            end
          end
        end
      end
    end
  end

  // Alarm time and ringing flag; any clear beats a simultaneous match
  always_comb begin
    ah1_d   = ah1_q;
    ah0_d   = ah0_q;
    am1_d   = am1_q;
    am0_d   = am0_q;
    alarm_d = alarm_q;
    if (load_alarm && in_valid_c) begin
      ah1_d = h1_in;
      ah0_d = h0_in;
      am1_d = m1_in;
      am0_d = m0_in;
    end
    if (stop_alarm || !set_alarm || timeout_c) alarm_d = 1'b0;
    else if (match_c)                          alarm_d = 1'b1;
  end

  // While in reset the clock tracks valid digit inputs, else 00:00
  always_ff @(posedge clk or negedge rst_bar) begin
    if (!rst_bar) begin
      presc_q <= '0;
      h1_q    <= in_valid_c ? h1_in : 2'd0;
      h0_q    <= in_valid_c ? h0_in : 4'd0;
      m1_q    <= in_valid_c ? m1_in : 3'd0;
      m0_q    <= in_valid_c ? m0_in : 4'd0;
      s1_q    <= 3'd0;
      s0_q    <= 4'd0;
      ah1_q   <= 2'd0;
      ah0_q   <= 4'd0;
      am1_q   <= 3'd0;
      am0_q   <= 4'd0;
      alarm_q <= 1'b0;
    end else begin
      presc_q <= presc_d;
      h1_q    <= h1_d;
      h0_q    <= h0_d;
      m1_q    <= m1_d;
      m0_q    <= m0_d;
      s1_q    <= s1_d;
      s0_q    <= s0_d;
      ah1_q   <= ah1_d;
      ah0_q   <= ah0_d;
      am1_q   <= am1_d;
      am0_q   <= am0_d;
      alarm_q <= alarm_d;
    end
  end

  assign alarm  = alarm_q;
  assign h1_out = h1_q;
  assign h0_out = h0_q;
  assign m1_out = m1_q;
  assign m0_out = m0_q;
  assign s1_out = s1_q;
  assign s0_out = s0_q;

endmodule

// File: tb/tb_alarm_clock.sv
// tb_alarm_clock: directed test-plan steps plus randomized traffic, checked against
// a seconds-of-day reference model; define ALARM_TIMEOUT_EN to match a timeout build.
module tb_alarm_clock;

  localparam int T = 10;

  logic       rst_bar, clk;
  logic [1:0] h1_in;
  logic [3:0] h0_in;
  logic [2:0] m1_in;
  logic [3:0] m0_in;
  logic       load_time, load_alarm, set_alarm, stop_alarm;
  logic       alarm;
  logic [1:0] h1_out;
  logic [3:0] h0_out;
  logic [2:0] m1_out;
  logic [3:0] m0_out;
  logic [2:0] s1_out;
  logic [3:0] s0_out;

  int vectors;
  int miscompares;

  // Reference model: time as seconds of day, alarm as minute of day
  int tod, al_min, presc, to_cnt;
  bit ring;

  alarm_clock #(.TICKS_PER_SEC(T)) dut (
    .rst_bar(rst_bar), .clk(clk),
    .h1_in(h1_in), .h0_in(h0_in), .m1_in(m1_in), .m0_in(m0_in),
    .load_time(load_time), .load_alarm(load_alarm),
    .set_alarm(set_alarm), .stop_alarm(stop_alarm),
    .alarm(alarm),
    .h1_out(h1_out), .h0_out(h0_out), .m1_out(m1_out), .m0_out(m0_out),
    .s1_out(s1_out), .s0_out(s0_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit in_ok();
    int hh;
    hh = int'(h1_in) * 10 + int'(h0_in);
    return (h1_in <= 2) && (h0_in <= 9) && (hh <= 23) && (m1_in <= 5) && (m0_in <= 9);
  endfunction

  function automatic int in_min();
    return (int'(h1_in) * 10 + int'(h0_in)) * 60 + int'(m1_in) * 10 + int'(m0_in);
  endfunction

  function automatic logic [20:0] pack(input bit al, input int hh, input int mm, input int ss);
    return {al, 2'(hh / 10), 4'(hh % 10), 3'(mm / 10), 4'(mm % 10), 3'(ss / 10), 4'(ss % 10)};
  endfunction

  function automatic string show(input logic [20:0] v);
    return $sformatf("%0h%0h:%0h%0h:%0h%0h alarm=%0b",
                     v[19:18], v[17:14], v[13:11], v[10:7], v[6:4], v[3:0], v[20]);
  endfunction

  task automatic compare(input string tag, input logic [20:0] exp);
    logic [20:0] obs;
    obs = {alarm, h1_out, h0_out, m1_out, m0_out, s1_out, s0_out};
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %s expected %s", tag, show(obs), show(exp));
    end
  endtask

  task automatic model_reset();
    tod    = in_ok() ? in_min() * 60 : 0;
    al_min = 0;
    ring   = 1'b0;
    presc  = 0;
    to_cnt = 0;
  endtask

  task automatic model_edge();
    bit tick, match, clr, v;
    if (!rst_bar) begin
      model_reset();
    end else begin
      v     = in_ok();
      tick  = (presc == T - 1);
      match = set_alarm && (tod / 60 == al_min) && (tod % 60 == 0);
      clr   = stop_alarm || !set_alarm;
`ifdef ALARM_TIMEOUT_EN
      if (ring && tick && to_cnt == 59) clr = 1'b1;
      to_cnt = ring ? (tick ? to_cnt + 1 : to_cnt) : 0;
`endif
      if (clr)        ring = 1'b0;
      else if (match) ring = 1'b1;
      if (load_alarm && v) al_min = in_min();
      if (load_time && v) begin
        tod   = in_min() * 60;
        presc = 0;
      end else if (tick) begin
        tod   = (tod + 1) % 86400;
        presc = 0;
      end else begin
        presc++;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare("model", pack(ring, tod / 3600, (tod / 60) % 60, tod % 60));
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic expect_t(input string tag, input int hh, input int mm, input int ss, input bit al);
    compare(tag, pack(al, hh, mm, ss));
  endtask

  task automatic drive(input int hh, input int mm);
    h1_in = 2'(hh / 10);
    h0_in = 4'(hh % 10);
    m1_in = 3'(mm / 10);
    m0_in = 4'(mm % 10);
  endtask

  task automatic load_time_to(input int hh, input int mm);
    drive(hh, mm);
    load_time = 1'b1;
    step();
    load_time = 1'b0;
  endtask

  localparam bit TO_EN =
`ifdef ALARM_TIMEOUT_EN
    1'b1;
`else
    1'b0;
`endif

  initial begin
    int nm;
    vectors     = 0;
    miscompares = 0;
    rst_bar     = 1'b0;
    load_time   = 1'b0;
    load_alarm  = 1'b0;
    set_alarm   = 1'b0;
    stop_alarm  = 1'b0;
    drive(11, 43);
    model_reset();

    // Reset loads valid digit inputs; first tick T cycles after release
    steps(3);
    rst_bar = 1'b1;
    expect_t("reset_1143", 11, 43, 0, 1'b0);
    steps(T - 1);
    expect_t("pre_first_tick", 11, 43, 0, 1'b0);
    step();
    expect_t("first_tick", 11, 43, 1, 1'b0);

    // Held load_time freezes at hh:mm:00
    drive(7, 10);
    load_time = 1'b1;
    steps(3);
    expect_t("load_held", 7, 10, 0, 1'b0);
    load_time = 1'b0;
    steps(60 * T - 1);
    expect_t("load_0710_59s", 7, 10, 59, 1'b0);
    step();
    expect_t("load_0710_60s", 7, 11, 0, 1'b0);

    // Day and hour-digit wraps
    load_time_to(23, 59);
    steps(60 * T);
    expect_t("wrap_midnight", 0, 0, 0, 1'b0);
    load_time_to(9, 59);
    steps(60 * T);
    expect_t("wrap_0959", 10, 0, 0, 1'b0);

    // Alarm rings one cycle after match, stop clears it for the rest of the minute
    drive(9, 5);
    load_alarm = 1'b1;
    set_alarm  = 1'b1;
    step();
    load_alarm = 1'b0;
    load_time_to(9, 4);
    steps(60 * T);
    expect_t("match_reached", 9, 5, 0, 1'b0);
    step();
    expect_t("alarm_rings", 9, 5, 0, 1'b1);
    steps(5 * T);
    stop_alarm = 1'b1;
    step();
    stop_alarm = 1'b0;
    expect_t("stop_clears", 9, 5, 5, 1'b0);
    steps(54 * T - 2);
    expect_t("stays_clear", 9, 5, 59, 1'b0);

    // Disarmed: no ring at match
    set_alarm = 1'b0;
    load_time_to(9, 4);
    steps(60 * T);
    step();
    expect_t("disarmed_no_ring", 9, 5, 0, 1'b0);

    // Invalid load 25:70 leaves time and alarm registers untouched
    h1_in = 2'd2; h0_in = 4'd5; m1_in = 3'd7; m0_in = 4'd0;
    load_time  = 1'b1;
    load_alarm = 1'b1;
    step();
    load_time  = 1'b0;
    load_alarm = 1'b0;
    expect_t("invalid_load", 9, 5, 0, 1'b0);

    // Alarm still 09:05; ring then hold or time out
    set_alarm = 1'b1;
    load_time_to(9, 4);
    steps(60 * T);
    step();
    expect_t("ring_again", 9, 5, 0, 1'b1);
    steps(59 * T - 1);
    expect_t("ring_59_ticks", 9, 5, 59, 1'b1);
    steps(T);
    expect_t("ring_60_ticks", 9, 6, 0, !TO_EN);
    steps(60 * T);
    expect_t("ring_120_ticks", 9, 7, 0, !TO_EN);
    set_alarm = 1'b0;
    step();
    expect_t("disarm_clears", 9, 7, 0, 1'b0);

    // Randomized traffic against the model
    set_alarm = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      h1_in = 2'($urandom_range(0, 3));
      h0_in = 4'($urandom_range(0, 11));
      m1_in = 3'($urandom_range(0, 6));
      m0_in = 4'($urandom_range(0, 10));
      load_time  = ($urandom_range(0, 299) == 0);
      load_alarm = ($urandom_range(0, 199) == 0);
      stop_alarm = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 399) == 0) set_alarm = ~set_alarm;
      if (i % 500 == 0) begin
        nm = (tod / 60 + 1) % 1440;
        drive(nm / 60, nm % 60);
        load_alarm = 1'b1;
        load_time  = 1'b0;
        set_alarm  = 1'b1;
      end
      if ($urandom_range(0, 599) == 0) begin
        rst_bar = 1'b0;
        #1;
        model_reset();
        compare("async_reset", pack(ring, tod / 3600, (tod / 60) % 60, tod % 60));
        step();
        rst_bar = 1'b1;
      end else begin
        step();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alarm_clock.md
Name: alarm_clock

Overview:
- 24-hour real-time clock (hh:mm:ss, BCD digit outputs) with one programmable alarm (hh:mm).
- Divides the system clock down to a 1 Hz tick, advances time, and compares against the stored alarm.
- Raises a latched `alarm` flag until acknowledged.
- Sits between front-panel controls (digit inputs, load/set/stop buttons) and a display/buzzer driver.

Parameters:
- TICKS_PER_SEC, 100: clk cycles per second tick. Range ≥1; the counter width is derived from it.

Ports:
- rst_bar input 1: asynchronous active-low reset.
- clk input 1: system clock; all state changes on the rising edge.
- h1_in input 2: hour tens digit input, 0-2.
- h0_in input 4: hour units digit input, 0-9.
- m1_in input 3: minute tens digit input, 0-5.
- m0_in input 4: minute units digit input, 0-9.
- load_time input 1: active-high; loads the clock time from the digit inputs.
- load_alarm input 1: active-high; loads the alarm time from the digit inputs.
- set_alarm input 1: level; 1 = alarm armed.
- stop_alarm input 1: active-high; clears a ringing alarm.
- alarm output 1: alarm ringing flag.
- h1_out output 2: current hour tens digit.
- h0_out output 4: current hour units digit.
- m1_out output 3: current minute tens digit.
- m0_out output 4: current minute units digit.
- s1_out output 3: current second tens digit.
- s0_out output 4: current second units digit.
- Positional port order: rst_bar, clk, h1_in, h0_in, m1_in, m0_in, load_time, load_alarm, set_alarm, stop_alarm, alarm, h1_out, h0_out, m1_out, m0_out, s1_out, s0_out.

Behaviour:
- Single clock domain, clk.
- Reset is asynchronous and active-low (rst_bar): asserting it acts immediately; release is sampled synchronously.
- While rst_bar=0:
  - Time digits take the digit inputs if valid, else 00:00.
  - Seconds = 00.
  - Alarm registers = 00:00.
  - alarm = 0.
  - Prescaler = 0.
- Input validity: h1_in ≤ 2, h0_in ≤ 9, h1_in:h0_in ≤ 23, m1_in ≤ 5, m0_in ≤ 9. Any load with invalid inputs is ignored; the target registers are unchanged.
- Prescaler counts 0..TICKS_PER_SEC-1. The tick is asserted in the cycle the counter wraps.
- On tick, time advances 1 s:
  - s0 9→0 carries to s1; s1:s0 59→00 carries to minutes.
  - m0 9→0 carries to m1; m1:m0 59→00 carries to hours.
  - h1:h0 09→10, 19→20, 23→00.
  - 23:59:59 → 00:00:00.
- load_time=1 (priority over ticking): every cycle, time = inputs, seconds = 00, prescaler = 0. Counting resumes on release; the first tick arrives TICKS_PER_SEC cycles later.
- load_alarm=1: alarm hh:mm = inputs (valid only). Time counting is unaffected. May coincide with load_time; both load.
- Match: set_alarm=1 and current hh:mm == alarm hh:mm and seconds == 00, evaluated on the registered time. alarm is set on the next clk edge.
- alarm is sticky once set. It is cleared by:
  - stop_alarm=1;
  - set_alarm=0;
  - reset.
- Clear has priority over a match in the same cycle.
- A match re-occurring with stop_alarm low re-sets alarm, i.e. the alarm rings again the next day.
- Outputs are registered; after reset they equal the reset digit values.
- Reset mid-count: time reloads from the inputs; no partial carry.

Optional Feature:
- ALARM_TIMEOUT_EN:
  - Defined: a ringing alarm auto-clears after 60 second-ticks without stop_alarm (auto-clear counter reset when alarm sets).
  - Undefined: alarm holds until stop_alarm, set_alarm=0, or reset.

Test Plan:
- Reset with inputs 11:43, release → outputs 11:43:00, alarm=0; after TICKS_PER_SEC cycles → 11:43:01.
- load_time pulse with inputs 07:10 → outputs 07:10:00 while held; 60 ticks after release → 07:11:00.
- Wrap: load 23:59, run 60 ticks → 00:00:00; load 09:59, run 60 ticks → 10:00:00.
- load_alarm 09:05, set_alarm=1, load_time 09:04, run 60 ticks → alarm=1 one cycle after 09:05:00; stop_alarm pulse → alarm=0 and stays 0 through 09:05:59.
- Same alarm setup but set_alarm=0 at the match → alarm stays 0; invalid load (inputs 25:70) → time and alarm registers unchanged.
- With ALARM_TIMEOUT_EN defined: alarm rings at the match and clears after 60 ticks without stop_alarm; undefined: still 1 after 120 ticks.
